// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_W     = 2;

   // Byte index of the most significant lane; a handshake here completes a word.
   localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_FINISH = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   // Running image checksum: plain modulo-2^32 word sum.
   function automatic logic [31:0] checksum_add(input logic [31:0] acc,
                                                input logic [31:0] word);
      return acc + word;
   endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects image bytes little-endian into 32-bit words. The three lower
// lanes are held in a shift register; the fourth byte is taken straight
// from the input so the completed word is available in the handshake cycle.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_data,
   output logic [1:0]  byte_idx,
   output logic        word_done,
   output logic [31:0] word
);

   logic [23:0] lanes_r;
   logic [1:0]  idx_r;

   // Shift each accepted byte in from the top so the first byte of a word ends in [7:0]
   always_ff @(posedge clock) begin
      if (reset) begin
         lanes_r <= 24'd0;
         idx_r   <= 2'd0;
      end else if (clear) begin
         lanes_r <= 24'd0;
         idx_r   <= 2'd0;
      end else if (accept) begin
         lanes_r <= {byte_data, lanes_r[23:8]};
         idx_r   <= idx_r + 2'd1;
      end
   end

   assign byte_idx  = idx_r;
   assign word_done = accept && (idx_r == LAST_BYTE_IDX);
   assign word      = {byte_data, lanes_r};

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a byte-stream program image, writes
// it word by word into instruction memory and releases the CPU from reset
// once the whole image is in place.
// Optional feature macro: LOADER_CHECKSUM_EN -- the final image word is a
// checksum (mod-2^32 sum of all preceding words), compared and not written.
module imem_loader
   import loader_pkg::*;
#(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   // Wide enough to hold MEM_WORDS itself, the "memory full" marker.
   localparam int WIDX_W = $clog2(MEM_WORDS + 1);

   state_t            state_r, next_state_s;
   logic [WIDX_W-1:0] word_idx_r, word_idx_s;
   logic              byte_ready_r, mem_we_r, cpu_reset_r, done_r, error_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [31:0]       mem_wdata_r;
   logic              hs_s, clear_s, write_s, word_done_s;
   logic [1:0]        byte_idx_s;
   logic [31:0]       word_s;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]       sum_r, sum_s;
`endif

   assign hs_s = byte_valid & byte_ready_r;

   word_assembler u_asm (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear_s),
      .accept    (hs_s),
      .byte_data (byte_data),
      .byte_idx  (byte_idx_s),
      .word_done (word_done_s),
      .word      (word_s)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode: word writes, overflow and truncation detection
   always_comb begin
      next_state_s = state_r;
      word_idx_s   = word_idx_r;
      clear_s      = 1'b0;
      write_s      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_s        = sum_r;
`endif
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               next_state_s = ST_LOAD;
               word_idx_s   = {WIDX_W{1'b0}};
               clear_s      = 1'b1;
`ifdef LOADER_CHECKSUM_EN
               sum_s        = 32'd0;
`endif
            end else begin
               next_state_s = state_r;
            end
         end
         ST_LOAD: begin
            if (!hs_s) begin
               next_state_s = ST_LOAD;
            end else if (word_idx_r == WIDX_W'(MEM_WORDS)) begin
               next_state_s = ST_ERROR;
            end else if (byte_last && (byte_idx_s != LAST_BYTE_IDX)) begin
               // Truncated final word: drop it rather than write a partial word.
               next_state_s = ST_ERROR;
            end else if (word_done_s) begin
`ifdef LOADER_CHECKSUM_EN
               if (byte_last) begin
                  next_state_s = (word_s == sum_r) ? ST_FINISH : ST_ERROR;
               end else begin
                  write_s      = 1'b1;
                  word_idx_s   = word_idx_r + WIDX_W'(1);
                  sum_s        = checksum_add(sum_r, word_s);
                  next_state_s = ST_LOAD;
               end
`else
               write_s    = 1'b1;
               word_idx_s = word_idx_r + WIDX_W'(1);
               if (byte_last) begin
                  next_state_s = ST_FINISH;
               end else begin
                  next_state_s = ST_LOAD;
               end
`endif
            end else begin
               next_state_s = ST_LOAD;
            end
         end
         ST_FINISH: begin
            next_state_s = ST_DONE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Counters, write port and status outputs, all registered from the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         word_idx_r   <= {WIDX_W{1'b0}};
         mem_we_r     <= 1'b0;
         mem_addr_r   <= {ADDR_W{1'b0}};
         mem_wdata_r  <= 32'd0;
         byte_ready_r <= 1'b0;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
         cpu_reset_r  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
         sum_r        <= 32'd0;
`endif
      end else begin
         word_idx_r   <= word_idx_s;
         mem_we_r     <= write_s;
         if (write_s) begin
            mem_addr_r  <= ADDR_W'({word_idx_r, 2'b00});
            mem_wdata_r <= word_s;
         end
         byte_ready_r <= (next_state_s == ST_LOAD);
         done_r       <= (next_state_s == ST_DONE);
         error_r      <= (next_state_s == ST_ERROR);
         cpu_reset_r  <= (next_state_s != ST_DONE);
`ifdef LOADER_CHECKSUM_EN
         sum_r        <= sum_s;
`endif
      end
   end

   assign byte_ready = byte_ready_r;
   assign mem_we     = mem_we_r;
   assign mem_addr   = mem_addr_r;
   assign mem_wdata  = mem_wdata_r;
   assign cpu_reset  = cpu_reset_r;
   assign done       = done_r;
   assign error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A large instance (16 words) carries
// most scenarios; a 2-word instance on the same inputs checks overflow.
`timescale 1ns/1ps
module tb_imem_loader;

   logic        clock = 1'b0;
   logic        reset, start, byte_valid, byte_last;
   logic [7:0]  byte_data;
   logic        ready1, we1, cpu1, done1, err1;
   logic [31:0] addr1, wdata1;
   logic        ready2, we2, cpu2, done2, err2;
   logic [31:0] addr2, wdata2;

   int tests = 0;
   int fails = 0;

   logic [7:0]  img[$];
   logic [63:0] exp_wr[$];
   logic [63:0] got1[$];
   logic [63:0] got2[$];
   int          exp_res;   // 0 still loading, 1 done, 2 error
   int          exp_hs;    // handshakes the loader takes before it stops

   always #5 clock = ~clock;

   imem_loader #(.MEM_WORDS(16), .ADDR_W(32)) dut (
      .clock(clock), .reset(reset), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_last(byte_last), .byte_ready(ready1),
      .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .cpu_reset(cpu1),
      .done(done1), .error(err1));

   imem_loader #(.MEM_WORDS(2), .ADDR_W(32)) dut_small (
      .clock(clock), .reset(reset), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_last(byte_last), .byte_ready(ready2),
      .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2), .cpu_reset(cpu2),
      .done(done2), .error(err2));

   // Record every memory write cycle of both instances
   always @(negedge clock) begin
      if (we1) got1.push_back({addr1, wdata1});
      if (we2) got2.push_back({addr2, wdata2});
   end

   // Reference: walk the image byte by byte with the loader's rules
   task automatic model_run(input int mem_words, input bit has_last);
      logic [31:0] w, sum;
      bit          last;
      exp_wr.delete();
      exp_res = 0;
      exp_hs  = img.size();
      sum     = 32'd0;
      for (int k = 0; k < img.size(); k++) begin
         last = has_last && (k == img.size() - 1);
         if (k / 4 >= mem_words) begin exp_res = 2; exp_hs = k + 1; return; end
         if (last && (k % 4) != 3) begin exp_res = 2; exp_hs = k + 1; return; end
         if (k % 4 == 3) begin
            w = {img[k], img[k-1], img[k-2], img[k-3]};
`ifdef LOADER_CHECKSUM_EN
            if (last) begin exp_res = (w == sum) ? 1 : 2; exp_hs = k + 1; return; end
            sum = sum + w;
`endif
            exp_wr.push_back({32'((k / 4) * 4), w});
            if (last) begin exp_res = 1; exp_hs = k + 1; return; end
         end
      end
   endtask

   function automatic logic [2:0] exp_flags(input int res);   // {done, error, cpu_reset}
      case (res)
         1:       return 3'b100;
         2:       return 3'b011;
         default: return 3'b001;
      endcase
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      got1.delete(); got2.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      got1.delete(); got2.delete();
   endtask

   // Offer img[first .. first+n-1] with min..max idle cycles before each byte
   task automatic send_bytes(input int first, input int n, input bit has_last,
                             input bit use_small, input int min_gap, input int max_gap);
      bit acc;
      int gap;
      for (int k = first; k < first + n; k++) begin
         gap = int'($urandom_range(max_gap, min_gap));
         for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0; byte_data = 8'($urandom); byte_last = 1'($urandom);
            @(negedge clock);
         end
         byte_valid = 1'b1; byte_data = img[k];
         byte_last  = has_last && (k == img.size() - 1);
         acc = 1'b0;
         for (int t = 0; t < 16 && !acc; t++) begin
            acc = use_small ? ready2 : ready1;
            @(negedge clock);
         end
         if (!acc) begin tests++; fails++; $display("FAIL send_timeout: byte %0d not accepted in 16 cycles", k); end
         byte_valid = 1'b0; byte_last = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_data = 8'h93; byte_last = 1'b1;
      @(negedge clock);
      tests++; if (cpu1 !== 1'b1)     begin fails++; $display("FAIL reset_cpu_reset: got %b want 1", cpu1); end
      tests++; if (done1 !== 1'b0)    begin fails++; $display("FAIL reset_done: got %b want 0", done1); end
      tests++; if (err1 !== 1'b0)     begin fails++; $display("FAIL reset_error: got %b want 0", err1); end
      tests++; if (we1 !== 1'b0)      begin fails++; $display("FAIL reset_mem_we: got %b want 0", we1); end
      tests++; if (ready1 !== 1'b0)   begin fails++; $display("FAIL reset_byte_ready: got %b want 0", ready1); end
      tests++; if (addr1 !== 32'd0)   begin fails++; $display("FAIL reset_mem_addr: got %h want 0", addr1); end
      tests++; if (wdata1 !== 32'd0)  begin fails++; $display("FAIL reset_mem_wdata: got %h want 0", wdata1); end
      reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
      @(negedge clock);
      tests++; if (ready1 !== 1'b0)   begin fails++; $display("FAIL reset_start_ignored: byte_ready got %b want 0", ready1); end
   endtask

   task automatic test_single();
      do_reset();
      img = '{8'h93, 8'h00, 8'h50, 8'h00};
      model_run(16, 1'b1);
      pulse_start();
      send_bytes(0, 4, 1'b1, 1'b0, 0, 0);
`ifndef LOADER_CHECKSUM_EN
      tests++; if (we1 !== 1'b1 || addr1 !== 32'h0 || wdata1 !== 32'h00500093)
         begin fails++; $display("FAIL single_write: got we=%b addr=%h data=%h want 1 0 00500093", we1, addr1, wdata1); end
      tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL single_done_early: got %b want 0", done1); end
      @(negedge clock);
      tests++; if (done1 !== 1'b1 || cpu1 !== 1'b0 || we1 !== 1'b0)
         begin fails++; $display("FAIL single_done: got done=%b cpu_reset=%b we=%b want 1 0 0", done1, cpu1, we1); end
`endif
      repeat (2) @(negedge clock);
      tests++; if (got1.size() != exp_wr.size()) begin fails++; $display("FAIL single_wr_count: got %0d want %0d", got1.size(), exp_wr.size()); end
      foreach (exp_wr[i]) begin
         tests++; if (i >= got1.size() || got1[i] !== exp_wr[i]) begin fails++; $display("FAIL single_wr%0d: got %h want %h", i, (i < got1.size()) ? got1[i] : 64'd0, exp_wr[i]); end
      end
      tests++; if ({done1, err1, cpu1} !== exp_flags(exp_res)) begin fails++; $display("FAIL single_flags: got %b want %b", {done1, err1, cpu1}, exp_flags(exp_res)); end
   endtask

   task automatic test_gaps();
      do_reset();
      img = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
      model_run(16, 1'b1);
      pulse_start();
      send_bytes(0, 8, 1'b1, 1'b0, 2, 2);
      repeat (3) @(negedge clock);
`ifndef LOADER_CHECKSUM_EN
      tests++; if (got1.size() != 2 || got1[0] !== {32'h0, 32'h00500093} || got1[1] !== {32'h4, 32'h00100113})
         begin fails++; $display("FAIL gaps_literal: got %0d writes, first %h", got1.size(), (got1.size() > 0) ? got1[0] : 64'd0); end
`endif
      tests++; if (got1.size() != exp_wr.size()) begin fails++; $display("FAIL gaps_wr_count: got %0d want %0d", got1.size(), exp_wr.size()); end
      foreach (exp_wr[i]) begin
         tests++; if (i >= got1.size() || got1[i] !== exp_wr[i]) begin fails++; $display("FAIL gaps_wr%0d: got %h want %h", i, (i < got1.size()) ? got1[i] : 64'd0, exp_wr[i]); end
      end
      tests++; if ({done1, err1, cpu1} !== exp_flags(exp_res)) begin fails++; $display("FAIL gaps_flags: got %b want %b", {done1, err1, cpu1}, exp_flags(exp_res)); end
   endtask

   task automatic test_truncated();
      do_reset();
      img = '{8'h93, 8'h00, 8'h50};
      model_run(16, 1'b1);
      pulse_start();
      send_bytes(0, 3, 1'b1, 1'b0, 0, 1);
      repeat (2) @(negedge clock);
      tests++; if (got1.size() != 0) begin fails++; $display("FAIL trunc_no_write: got %0d writes want 0", got1.size()); end
      tests++; if ({done1, err1, cpu1} !== exp_flags(exp_res)) begin fails++; $display("FAIL trunc_flags: got %b want %b", {done1, err1, cpu1}, exp_flags(exp_res)); end
      pulse_start();
      tests++; if (ready1 !== 1'b1 || err1 !== 1'b0 || cpu1 !== 1'b1)
         begin fails++; $display("FAIL trunc_restart: got ready=%b error=%b cpu_reset=%b want 1 0 1", ready1, err1, cpu1); end
   endtask

   task automatic test_overflow();
      do_reset();
      img.delete();
      for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
      model_run(2, 1'b1);
      pulse_start();
      send_bytes(0, exp_hs, 1'b1, 1'b1, 0, 1);
      repeat (2) @(negedge clock);
      tests++; if (got2.size() != exp_wr.size()) begin fails++; $display("FAIL ovf_wr_count: got %0d want %0d", got2.size(), exp_wr.size()); end
      foreach (exp_wr[i]) begin
         tests++; if (i >= got2.size() || got2[i] !== exp_wr[i]) begin fails++; $display("FAIL ovf_wr%0d: got %h want %h", i, (i < got2.size()) ? got2[i] : 64'd0, exp_wr[i]); end
      end
      tests++; if ({done2, err2, cpu2, ready2} !== {exp_flags(exp_res), 1'b0}) begin fails++; $display("FAIL ovf_flags: got %b want %b", {done2, err2, cpu2, ready2}, {exp_flags(exp_res), 1'b0}); end
   endtask

   task automatic test_start_ignored();
      do_reset();
      img.delete();
      for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
      model_run(16, 1'b1);
      pulse_start();
      send_bytes(0, 2, 1'b1, 1'b0, 0, 1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      send_bytes(2, 6, 1'b1, 1'b0, 0, 1);
      repeat (2) @(negedge clock);
      tests++; if (got1.size() != exp_wr.size()) begin fails++; $display("FAIL ign_wr_count: got %0d want %0d", got1.size(), exp_wr.size()); end
      foreach (exp_wr[i]) begin
         tests++; if (i >= got1.size() || got1[i] !== exp_wr[i]) begin fails++; $display("FAIL ign_wr%0d: got %h want %h", i, (i < got1.size()) ? got1[i] : 64'd0, exp_wr[i]); end
      end
      tests++; if ({done1, err1, cpu1} !== exp_flags(exp_res)) begin fails++; $display("FAIL ign_flags: got %b want %b", {done1, err1, cpu1}, exp_flags(exp_res)); end
   endtask

   task automatic test_reset_midload();
      do_reset();
      img.delete();
      for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
      pulse_start();
      send_bytes(0, 7, 1'b0, 1'b0, 0, 1);
      tests++; if (got1.size() != 1) begin fails++; $display("FAIL mid_first_word: got %0d writes want 1", got1.size()); end
      // Reset collides with a word-completing handshake and a start
      reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_data = img[7]; byte_last = 1'b0;
      @(negedge clock);
      tests++; if (we1 !== 1'b0 || ready1 !== 1'b0) begin fails++; $display("FAIL mid_reset_prio: got we=%b ready=%b want 0 0", we1, ready1); end
      reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
      got1.delete();
      img.delete();
      for (int i = 0; i < 4; i++) img.push_back(8'($urandom));
      model_run(16, 1'b1);
      pulse_start();
      send_bytes(0, 4, 1'b1, 1'b0, 0, 2);
      repeat (2) @(negedge clock);
      tests++; if (got1.size() != exp_wr.size()) begin fails++; $display("FAIL mid_wr_count: got %0d want %0d", got1.size(), exp_wr.size()); end
      foreach (exp_wr[i]) begin
         tests++; if (i >= got1.size() || got1[i] !== exp_wr[i]) begin fails++; $display("FAIL mid_wr%0d: got %h want %h", i, (i < got1.size()) ? got1[i] : 64'd0, exp_wr[i]); end
      end
      tests++; if ({done1, err1, cpu1} !== exp_flags(exp_res)) begin fails++; $display("FAIL mid_flags: got %b want %b", {done1, err1, cpu1}, exp_flags(exp_res)); end
   endtask

   task automatic test_random();
      int          nwords, len;
      logic [31:0] s;
      do_reset();
      for (int it = 0; it < 12; it++) begin
         nwords = int'($urandom_range(5, 1));
         len    = 4 * nwords;
         if ($urandom_range(3, 0) == 0) len = len - int'($urandom_range(3, 1));
         if (len < 1) len = 1;
         img.delete();
         for (int i = 0; i < len; i++) img.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
         if (len % 4 == 0 && $urandom_range(1, 0) == 1) begin
            s = 32'd0;
            for (int w = 0; w < nwords - 1; w++) s = s + {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
            img[len-4] = s[7:0]; img[len-3] = s[15:8]; img[len-2] = s[23:16]; img[len-1] = s[31:24];
         end
`else
         s = 32'd0;
`endif
         model_run(16, 1'b1);
         pulse_start();
         send_bytes(0, exp_hs, 1'b1, 1'b0, 0, 3);
         repeat (2) @(negedge clock);
         tests++; if (got1.size() != exp_wr.size()) begin fails++; $display("FAIL rand%0d_wr_count: got %0d want %0d", it, got1.size(), exp_wr.size()); end
         foreach (exp_wr[i]) begin
            tests++; if (i >= got1.size() || got1[i] !== exp_wr[i]) begin fails++; $display("FAIL rand%0d_wr%0d: got %h want %h", it, i, (i < got1.size()) ? got1[i] : 64'd0, exp_wr[i]); end
         end
         tests++; if ({done1, err1, cpu1} !== exp_flags(exp_res)) begin fails++; $display("FAIL rand%0d_flags: got %b want %b", it, {done1, err1, cpu1}, exp_flags(exp_res)); end
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      for (int v = 0; v < 2; v++) begin
         do_reset();
         img = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'hA6, 8'h01, 8'h60, 8'h00};
         if (v == 1) begin img[8] = 8'h00; img[9] = 8'h00; img[10] = 8'h00; img[11] = 8'h00; end
         pulse_start();
         send_bytes(0, 12, 1'b1, 1'b0, 0, 1);
         repeat (2) @(negedge clock);
         tests++; if (got1.size() != 2) begin fails++; $display("FAIL csum%0d_wr_count: got %0d want 2", v, got1.size()); end
         tests++; if ({done1, err1} !== ((v == 0) ? 2'b10 : 2'b01)) begin fails++; $display("FAIL csum%0d_flags: got done=%b error=%b", v, done1, err1); end
      end
   endtask
`endif

   initial begin
      reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
      @(negedge clock);
      test_reset();
      test_single();
      test_gaps();
      test_truncated();
      test_overflow();
      test_start_ignored();
      test_reset_midload();
      test_random();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
